// File: rtl/pfb_snap_capture_pkg.sv
// Shared state encoding and default widths for the PFB snapshot capture path.
// The width defaults match port A of the snapshot BRAM wrapper.
package pfb_snap_capture_pkg;

  localparam int unsigned SNAP_DWIDTH = 64;
  localparam int unsigned SNAP_AWIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/pfb_snap_capture_pulse_edge_detect.sv
// Rising-edge detect for a software-written control level.
// A level already high when reset releases is not reported as an edge.
module pulse_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_c
);

  logic sig_q;
  logic primed_q;

  // primed_q masks the first cycle after reset, while sig_q still holds its reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q    <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      sig_q    <= sig_i;
      primed_q <= 1'b1;
    end
  end

  assign rise_c = sig_i & ~sig_q & primed_q;

endmodule

// File: rtl/pfb_snap_capture.sv
// Snapshot capture controller: on arm (optionally gated by PFB sync), writes
// 2^AWIDTH valid samples into snapshot BRAM port A, then flags done.
module pfb_snap_capture
  import pfb_snap_capture_pkg::*;
#(
  parameter int unsigned DWIDTH = SNAP_DWIDTH,
  parameter int unsigned AWIDTH = SNAP_AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] din,
  input  logic              din_valid,
  input  logic              sync_in,
  input  logic              arm,
  input  logic              use_sync,
  output logic              bram_we,
  output logic              bram_en_a,
  output logic [AWIDTH-1:0] bram_addr,
  output logic [DWIDTH-1:0] bram_wr_data,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH:0]   wr_count
);

  localparam int unsigned CW = AWIDTH + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(1) << AWIDTH;
  localparam logic [CW-1:0] LAST_IDX = FULL_CNT - CW'(1);

  cap_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic arm_rise;
  logic trigger;
  logic accept;

  pulse_edge_detect u_arm_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (arm),
    .rise_c (arm_rise)
  );

  // wr_count doubles as the write pointer: its low bits are the next address
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    trigger = use_sync ? sync_in : 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (arm_rise) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end
      end
      ST_ARMED: begin
        if (trigger) begin
          state_d = ST_CAPTURE;
          accept  = din_valid;
        end
      end
      ST_CAPTURE: begin
        accept = din_valid;
      end
      ST_DONE: begin
        if (arm_rise) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      we_d   = 1'b1;
      addr_d = cnt_q[AWIDTH-1:0];
      data_d = din;
      if (cnt_q != FULL_CNT) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (cnt_q == LAST_IDX) begin
        state_d = ST_DONE;
      end
    end

    busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bram_we      = we_q;
  assign bram_en_a    = we_q;
  assign bram_addr    = addr_q;
  assign bram_wr_data = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign wr_count     = cnt_q;

endmodule

// File: tb/tb_pfb_snap_capture.sv
// Self-checking bench for pfb_snap_capture: vector table, logged captures
// checked against a transaction-level reference, and hand-written corner cases.
module tb_pfb_snap_capture;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 10;
  localparam int          DEPTH = 1 << AW;
  localparam int          MAXC  = 4096;
  localparam int          NV    = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          sync_in;
  logic          arm;
  logic          use_sync;
  logic          bram_we;
  logic          bram_en_a;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wr_data;
  logic          busy;
  logic          done;
  logic [AW:0]   wr_count;

  int errors = 0;
  int checks = 0;

  pfb_snap_capture #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .din_valid    (din_valid),
    .sync_in      (sync_in),
    .arm          (arm),
    .use_sync     (use_sync),
    .bram_we      (bram_we),
    .bram_en_a    (bram_en_a),
    .bram_addr    (bram_addr),
    .bram_wr_data (bram_wr_data),
    .busy         (busy),
    .done         (done),
    .wr_count     (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          arm;
    logic          us;
    logic          sync;
    logic          valid;
    logic [DW-1:0] din;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          busy;
    logic          done;
    logic [AW:0]   cnt;
  } vec_t;

  vec_t tbl [NV];

  // per-cycle log: inputs driven in cycle i, outputs seen in cycle i
  logic          lv  [MAXC];
  logic          ls  [MAXC];
  logic [DW-1:0] ld  [MAXC];
  logic          ow  [MAXC];
  logic          oen [MAXC];
  logic [AW-1:0] oa  [MAXC];
  logic [DW-1:0] od  [MAXC];
  logic          ob  [MAXC];
  logic          odn [MAXC];
  logic [AW:0]   oc  [MAXC];

  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_step(input logic a, input logic s, input logic v, input logic [DW-1:0] d);
    arm       = a;
    sync_in   = s;
    din_valid = v;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic log_step(input int i, input logic a, input logic s, input logic v, input logic [DW-1:0] d);
    lv[i] = v;
    ls[i] = s;
    ld[i] = d;
    drive_step(a, s, v, d);
    ow[i+1]  = bram_we;
    oen[i+1] = bram_en_a;
    oa[i+1]  = bram_addr;
    od[i+1]  = bram_wr_data;
    ob[i+1]  = busy;
    odn[i+1] = done;
    oc[i+1]  = wr_count;
  endtask

  // Reference: from the arm edge at t0, find the trigger cycle, take the first
  // DEPTH valid cycles from there, and derive every output cycle by cycle.
  task automatic check_log(input string nm, input int t0, input bit us, input int n);
    int acc[$];
    int s;
    int last;
    int k;
    logic ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] edat;
    s = -1;
    for (int c = t0 + 1; c < n; c++) begin
      if (!us || ls[c]) begin
        s = c;
        break;
      end
    end
    if (s >= 0) begin
      for (int c = s; c < n && acc.size() < DEPTH; c++) begin
        if (lv[c]) acc.push_back(c);
      end
    end
    checks++;
    if (acc.size() != DEPTH || acc[DEPTH-1] >= n) begin
      errors++;
      $display("FAIL %s_complete: reference accepted %0d of %0d samples in log", nm, acc.size(), DEPTH);
      return;
    end
    last = acc[DEPTH-1];
    k    = 0;
    ea   = hold_addr;
    edat = hold_data;
    for (int c = t0 + 1; c <= n; c++) begin
      ew = (k < DEPTH) && (acc[k] == c - 1);
      if (ew) begin
        ea   = AW'(k);
        edat = ld[c-1];
        k++;
      end
      chk($sformatf("%s_we@%0d", nm, c),   DW'(ow[c]),  DW'(ew));
      chk($sformatf("%s_en@%0d", nm, c),   DW'(oen[c]), DW'(ew));
      chk($sformatf("%s_addr@%0d", nm, c), DW'(oa[c]),  DW'(ea));
      chk($sformatf("%s_data@%0d", nm, c), od[c],       edat);
      chk($sformatf("%s_busy@%0d", nm, c), DW'(ob[c]),  DW'(c <= last));
      chk($sformatf("%s_done@%0d", nm, c), DW'(odn[c]), DW'(c > last));
      chk($sformatf("%s_cnt@%0d", nm, c),  DW'(oc[c]),  DW'(k));
    end
    hold_addr = ea;
    hold_data = edat;
  endtask

  initial begin
    int nwr;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h11,   1'b0, 10'd0, 64'h0,    1'b0, 1'b0, 11'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h22,   1'b0, 10'd0, 64'h0,    1'b0, 1'b0, 11'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 64'h23,   1'b0, 10'd0, 64'h0,    1'b0, 1'b0, 11'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h33,   1'b0, 10'd0, 64'h0,    1'b1, 1'b0, 11'd0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h44,   1'b0, 10'd0, 64'h0,    1'b1, 1'b0, 11'd0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 64'hABCD, 1'b1, 10'd0, 64'hABCD, 1'b1, 1'b0, 11'd1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h99,   1'b0, 10'd0, 64'hABCD, 1'b1, 1'b0, 11'd1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h55,   1'b1, 10'd1, 64'h55,   1'b1, 1'b0, 11'd2};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h66,   1'b1, 10'd2, 64'h66,   1'b1, 1'b0, 11'd3};

    // reset with arm held high
    rst_n = 1'b0; arm = 1'b1; use_sync = 1'b0; sync_in = 1'b0; din_valid = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we",   DW'(bram_we),   DW'(0));
    chk("rst_en",   DW'(bram_en_a), DW'(0));
    chk("rst_addr", DW'(bram_addr), DW'(0));
    chk("rst_data", bram_wr_data,   DW'(0));
    chk("rst_busy", DW'(busy),      DW'(0));
    chk("rst_done", DW'(done),      DW'(0));
    chk("rst_cnt",  DW'(wr_count),  DW'(0));
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      use_sync = tbl[i].us;
      drive_step(tbl[i].arm, tbl[i].sync, tbl[i].valid, tbl[i].din);
      chk($sformatf("vec%0d_we", i),   DW'(bram_we),   DW'(tbl[i].we));
      chk($sformatf("vec%0d_addr", i), DW'(bram_addr), DW'(tbl[i].addr));
      chk($sformatf("vec%0d_data", i), bram_wr_data,   tbl[i].data);
      chk($sformatf("vec%0d_busy", i), DW'(busy),      DW'(tbl[i].busy));
      chk($sformatf("vec%0d_done", i), DW'(done),      DW'(tbl[i].done));
      chk($sformatf("vec%0d_cnt", i),  DW'(wr_count),  DW'(tbl[i].cnt));
    end
    for (int k = 3; k < DEPTH; k++) drive_step(1'b1, 1'b0, 1'b1, DW'(k));
    chk("vec_end_we",   DW'(bram_we),   DW'(1));
    chk("vec_end_addr", DW'(bram_addr), DW'(DEPTH - 1));
    chk("vec_end_done", DW'(done),      DW'(1));
    chk("vec_end_busy", DW'(busy),      DW'(0));
    chk("vec_end_cnt",  DW'(wr_count),  DW'(DEPTH));
    drive_step(1'b0, 1'b0, 1'b1, '1);
    chk("vec_post_we",   DW'(bram_we),   DW'(0));
    chk("vec_post_addr", DW'(bram_addr), DW'(DEPTH - 1));
    chk("vec_post_data", bram_wr_data,   DW'(DEPTH - 1));
    chk("vec_post_done", DW'(done),      DW'(1));
    chk("vec_post_cnt",  DW'(wr_count),  DW'(DEPTH));
    hold_addr = AW'(DEPTH - 1);
    hold_data = DW'(DEPTH - 1);

    // free-run ramp, arm rises at cycle 10
    use_sync = 1'b0;
    for (int i = 0; i < 1040; i++)
      log_step(i, i >= 10, 1'b0, 1'b1, (i >= 11) ? DW'(i - 11) : DW'(i + 5000));
    check_log("free", 10, 1'b0, 1040);
    chk("free_first_we",   DW'(ow[12]),   DW'(1));
    chk("free_first_data", od[12],        DW'(0));
    chk("free_last_addr",  DW'(oa[1035]), DW'(1023));
    chk("free_last_data",  od[1035],      DW'(1023));
    chk("free_done_1034",  DW'(odn[1034]), DW'(0));
    chk("free_done_1035",  DW'(odn[1035]), DW'(1));
    chk("free_cnt_1035",   DW'(oc[1035]), DW'(1024));

    // sync-triggered, single sync at cycle 50
    use_sync = 1'b1;
    for (int i = 0; i < 1080; i++)
      log_step(i, i >= 5, i == 50, (i >= 50) ? 1'b1 : 1'($urandom % 2),
               (i == 50) ? DW'(64'hABCD) : {$urandom, $urandom});
    check_log("sync", 5, 1'b1, 1080);
    nwr = 0;
    for (int c = 1; c <= 50; c++) nwr += int'(ow[c]);
    chk("sync_no_early_wr", DW'(nwr),    DW'(0));
    chk("sync_first_addr",  DW'(oa[51]), DW'(0));
    chk("sync_first_data",  od[51],      DW'(64'hABCD));

    // valid pattern 1,0,0,1 repeating
    use_sync = 1'b0;
    for (int i = 0; i < 2100; i++)
      log_step(i, i >= 3, 1'b0, (i % 4 == 0) || (i % 4 == 3), {$urandom, $urandom});
    check_log("gaps", 3, 1'b0, 2100);

    // random valid and sync, sync-gated
    use_sync = 1'b1;
    for (int i = 0; i < 2000; i++)
      log_step(i, i >= 2, (i == 40) || ($urandom % 16 == 0), ($urandom % 4) != 0, {$urandom, $urandom});
    check_log("rand", 2, 1'b1, 2000);

    // arm toggled while address 300 is written is ignored
    use_sync = 1'b0;
    for (int i = 0; i < 1040; i++)
      log_step(i, (i >= 2) && (i != 304), 1'b0, 1'b1, DW'(i));
    check_log("rearm", 2, 1'b0, 1040);

    // fresh arm edge in DONE restarts at address 0
    drive_step(1'b0, 1'b0, 1'b1, DW'(1));
    chk("done_hold", DW'(done), DW'(1));
    drive_step(1'b1, 1'b0, 1'b1, DW'(64'h777));
    chk("rearm_done", DW'(done),     DW'(0));
    chk("rearm_busy", DW'(busy),     DW'(1));
    chk("rearm_we",   DW'(bram_we),  DW'(0));
    chk("rearm_cnt",  DW'(wr_count), DW'(0));
    drive_step(1'b1, 1'b0, 1'b1, DW'(64'h5A5A));
    chk("rearm_first_we",   DW'(bram_we),   DW'(1));
    chk("rearm_first_addr", DW'(bram_addr), DW'(0));
    chk("rearm_first_data", bram_wr_data,   DW'(64'h5A5A));
    chk("rearm_first_cnt",  DW'(wr_count),  DW'(1));

    // reset mid-capture at address 500
    for (int k = 1; k <= 500; k++) drive_step(1'b1, 1'b0, 1'b1, DW'(k));
    chk("mid_addr", DW'(bram_addr), DW'(500));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we",   DW'(bram_we),   DW'(0));
    chk("mid_rst_busy", DW'(busy),      DW'(0));
    chk("mid_rst_done", DW'(done),      DW'(0));
    chk("mid_rst_cnt",  DW'(wr_count),  DW'(0));
    chk("mid_rst_addr", DW'(bram_addr), DW'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_step(1'b1, 1'b0, 1'b1, DW'(1));
    drive_step(1'b1, 1'b0, 1'b1, DW'(2));
    chk("post_rst_idle_busy", DW'(busy),    DW'(0));
    chk("post_rst_idle_we",   DW'(bram_we), DW'(0));
    drive_step(1'b0, 1'b0, 1'b1, DW'(3));
    drive_step(1'b1, 1'b0, 1'b1, DW'(4));
    chk("post_rst_busy", DW'(busy), DW'(1));
    drive_step(1'b1, 1'b0, 1'b1, DW'(64'hBEEF));
    chk("post_rst_we",   DW'(bram_we),   DW'(1));
    chk("post_rst_addr", DW'(bram_addr), DW'(0));
    chk("post_rst_data", bram_wr_data,   DW'(64'hBEEF));
    chk("post_rst_cnt",  DW'(wr_count),  DW'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
